pipe_control: RTL and testbench
===============================

PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port opcode  in  6  IF/ID instruction bits [31:26].
REQ-005 SHALL have ports if_id_rs, if_id_rt  in  5 each  IF/ID source register fields.
REQ-006 SHALL have port mem_zero  in  1  ALU zero flag latched in EX/MEM.
REQ-007 SHALL have port ex_aluop  out  2  ALU-control opcode for EX (00 lw/sw, 01 beq, 10 R-type, 11 invalid).
REQ-008 SHALL have ports ex_alusrc, ex_regdst  out  1 each  EX mux selects.
REQ-009 SHALL have ports mem_read, mem_write  out  1 each  MEM-stage data-memory strobes.
REQ-010 SHALL have ports wb_regwrite, wb_memtoreg  out  1 each  WB-stage controls.
REQ-011 SHALL have ports pc_write, if_id_write, if_flush, pc_src  out  1 each  fetch-side sequencing.
REQ-012 SHALL have port stall_cnt  out  CNT_W  stall-cycle count.

Function
REQ-013 SHALL decode opcode: 000000 R-type (regdst=1, aluop=10, regwrite=1); 100011 lw (alusrc=1, memread=1, regwrite=1, memtoreg=1, aluop=00); 101011 sw (alusrc=1, memwrite=1, aluop=00); 000100 beq (branch=1, aluop=01).
REQ-014 SHALL decode every other opcode to aluop=11 with all write/read/branch bits 0.
REQ-015 SHALL carry decoded controls through registered ID/EX, EX/MEM, MEM/WB stages, one stage per clk; ex_* from ID/EX, mem_* and branch from EX/MEM, wb_* from MEM/WB.
REQ-016 SHALL capture if_id_rt into ID/EX alongside controls.
REQ-017 SHALL detect load-use: ID/EX memread=1 and ID/EX rt equals if_id_rs or if_id_rt (rt ignored for lw opcode); rt=0 SHALL NOT trigger.
REQ-018 On load-use, SHALL drive pc_write=0, if_id_write=0 combinationally and load a bubble (all controls 0, aluop=00) into ID/EX at the next edge.
REQ-019 SHALL drive pc_src=1, if_flush=1 combinationally when EX/MEM branch=1 and mem_zero=1.
REQ-020 On taken branch, SHALL load bubbles into ID/EX and EX/MEM at the next edge.
REQ-021 Taken branch and load-use in the same cycle: flush wins; pc_write=1, if_id_write=1, no stall counted.
REQ-022 pc_write and if_id_write SHALL be 1 whenever no load-use stall is active.
REQ-023 Stall-counter logic SHALL increment stall_cnt once per load-use stall cycle, saturating at all-ones.

Reset
REQ-024 On rst, SHALL asynchronously clear all stage registers to bubble; ex_aluop=00, all mem_*/wb_*/ex_* outputs=0.
REQ-025 During and after rst, SHALL drive pc_write=1, if_id_write=1, if_flush=0, pc_src=0, stall_cnt=0.
REQ-026 rst asserted mid-stall or mid-flush SHALL abort it; first post-reset cycle decodes opcode normally.

Configuration
REQ-027 With STALL_COUNT_EN defined, SHALL implement stall_cnt per REQ-023.
REQ-028 Without STALL_COUNT_EN, SHALL keep stall_cnt port, tie it to 0, and synthesize no counter.

Verification
REQ-029 Release rst, opcode=000000 held -> ex_aluop=10 at cycle 1, wb_regwrite=1 at cycle 3, pc_write=1 throughout.
REQ-030 lw (rt=5) then R-type with rs=5 -> one cycle pc_write=0/if_id_write=0, next ID/EX bubble, stall_cnt 0->1 (STALL_COUNT_EN).
REQ-031 lw rt=0 then R-type rs=0 -> no stall, stall_cnt stays 0.
REQ-032 beq reaching EX/MEM with mem_zero=1 -> pc_src=1, if_flush=1 for one cycle; next cycle mem_read=mem_write=0, ex_aluop=00.
REQ-033 Taken branch coinciding with load-use -> pc_write=1, stall_cnt unchanged; opcode=111111 -> ex_aluop=11, no writes.
REQ-034 stall_cnt preloaded near all-ones (CNT_W=4, 15 stalls) plus one more stall -> holds 4'hF; rst mid-stall -> immediate bubble outputs, stall_cnt=0.

Source files
------------

// File: rtl/pipe_control.sv
// Control unit for a 5-stage MIPS subset pipeline: decode, stage control registers and
// load-use / branch-flush sequencing. Define STALL_COUNT_EN to build the stall-cycle counter.
module pipe_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             mem_zero,
  output logic [1:0]       ex_aluop,
  output logic             ex_alusrc,
  output logic             ex_regdst,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_flush,
  output logic             pc_src,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;

  logic       w_regdst, w_alusrc, w_memread, w_memwrite, w_branch, w_regwrite, w_memtoreg;
  logic [1:0] w_aluop;
  logic       w_load_use, w_flush, w_stall;

  logic       r_idex_regdst, r_idex_alusrc, r_idex_memread, r_idex_memwrite;
  logic       r_idex_branch, r_idex_regwrite, r_idex_memtoreg;
  logic [1:0] r_idex_aluop;
  logic [4:0] r_idex_rt;
  logic       r_exmem_memread, r_exmem_memwrite, r_exmem_branch;
  logic       r_exmem_regwrite, r_exmem_memtoreg;
  logic       r_memwb_regwrite, r_memwb_memtoreg;

  always_comb begin
    w_regdst   = 1'b0;
    w_alusrc   = 1'b0;
    w_aluop    = 2'b11;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_branch   = 1'b0;
    w_regwrite = 1'b0;
    w_memtoreg = 1'b0;
    case (opcode)
      OpRtype: begin
        w_regdst   = 1'b1;
        w_aluop    = 2'b10;
        w_regwrite = 1'b1;
      end
      OpLw: begin
        w_alusrc   = 1'b1;
        w_aluop    = 2'b00;
        w_memread  = 1'b1;
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      OpSw: begin
        w_alusrc   = 1'b1;
        w_aluop    = 2'b00;
        w_memwrite = 1'b1;
      end
      OpBeq: begin
        w_aluop  = 2'b01;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  // The rt field of a following lw is its destination, so it cannot consume the load result.
  assign w_load_use = r_idex_memread && (r_idex_rt != 5'd0) &&
                      ((r_idex_rt == if_id_rs) || ((r_idex_rt == if_id_rt) && (opcode != OpLw)));
  assign w_flush    = r_exmem_branch & mem_zero;
  assign w_stall    = w_load_use & ~w_flush;

  assign pc_write    = ~w_stall;
  assign if_id_write = ~w_stall;
  assign if_flush    = w_flush;
  assign pc_src      = w_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idex_regdst    <= 1'b0;
      r_idex_alusrc    <= 1'b0;
      r_idex_aluop     <= 2'b00;
      r_idex_memread   <= 1'b0;
      r_idex_memwrite  <= 1'b0;
      r_idex_branch    <= 1'b0;
      r_idex_regwrite  <= 1'b0;
      r_idex_memtoreg  <= 1'b0;
      r_idex_rt        <= 5'd0;
      r_exmem_memread  <= 1'b0;
      r_exmem_memwrite <= 1'b0;
      r_exmem_branch   <= 1'b0;
      r_exmem_regwrite <= 1'b0;
      r_exmem_memtoreg <= 1'b0;
      r_memwb_regwrite <= 1'b0;
      r_memwb_memtoreg <= 1'b0;
    end else begin
      if (w_stall || w_flush) begin
        r_idex_regdst   <= 1'b0;
        r_idex_alusrc   <= 1'b0;
        r_idex_aluop    <= 2'b00;
        r_idex_memread  <= 1'b0;
        r_idex_memwrite <= 1'b0;
        r_idex_branch   <= 1'b0;
        r_idex_regwrite <= 1'b0;
        r_idex_memtoreg <= 1'b0;
      end else begin
        r_idex_regdst   <= w_regdst;
        r_idex_alusrc   <= w_alusrc;
        r_idex_aluop    <= w_aluop;
        r_idex_memread  <= w_memread;
        r_idex_memwrite <= w_memwrite;
        r_idex_branch   <= w_branch;
        r_idex_regwrite <= w_regwrite;
        r_idex_memtoreg <= w_memtoreg;
      end
      r_idex_rt <= if_id_rt;

      if (w_flush) begin
        r_exmem_memread  <= 1'b0;
        r_exmem_memwrite <= 1'b0;
        r_exmem_branch   <= 1'b0;
        r_exmem_regwrite <= 1'b0;
        r_exmem_memtoreg <= 1'b0;
      end else begin
        r_exmem_memread  <= r_idex_memread;
        r_exmem_memwrite <= r_idex_memwrite;
        r_exmem_branch   <= r_idex_branch;
        r_exmem_regwrite <= r_idex_regwrite;
        r_exmem_memtoreg <= r_idex_memtoreg;
      end

      r_memwb_regwrite <= r_exmem_regwrite;
      r_memwb_memtoreg <= r_exmem_memtoreg;
    end
  end

  assign ex_aluop    = r_idex_aluop;
  assign ex_alusrc   = r_idex_alusrc;
  assign ex_regdst   = r_idex_regdst;
  assign mem_read    = r_exmem_memread;
  assign mem_write   = r_exmem_memwrite;
  assign wb_regwrite = r_memwb_regwrite;
  assign wb_memtoreg = r_memwb_memtoreg;

`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares. Stall-count expectations follow STALL_COUNT_EN.
module tb_pipe_control;

  localparam int unsigned CntW = 4;
  localparam logic [5:0] OpR   = 6'h00;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpSw  = 6'h2B;
  localparam logic [5:0] OpBeq = 6'h04;
  localparam logic [5:0] OpInv = 6'h3F;

  // Instruction kind occupying a pipeline stage.
  typedef enum int {KB, KR, KL, KS, KQ, KI} kind_t;

  typedef struct {
    string       nm;
    logic [11:0] ctl;
    logic [3:0]  cnt;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [5:0]      opcode;
  logic [4:0]      if_id_rs, if_id_rt;
  logic            mem_zero;
  logic [1:0]      ex_aluop;
  logic            ex_alusrc, ex_regdst, mem_read, mem_write, wb_regwrite, wb_memtoreg;
  logic            pc_write, if_id_write, if_flush, pc_src;
  logic [CntW-1:0] stall_cnt;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  pipe_control #(.CNT_W(CntW)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .if_id_rs    (if_id_rs),
    .if_id_rt    (if_id_rt),
    .mem_zero    (mem_zero),
    .ex_aluop    (ex_aluop),
    .ex_alusrc   (ex_alusrc),
    .ex_regdst   (ex_regdst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .wb_regwrite (wb_regwrite),
    .wb_memtoreg (wb_memtoreg),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_flush    (if_flush),
    .pc_src      (pc_src),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {aluop, alusrc, regdst, mem_read, mem_write, wb_regwrite, wb_memtoreg,
  //  pc_write, if_id_write, if_flush, pc_src}
  function automatic logic [11:0] exp_ctl(input kind_t ki, input kind_t ke, input kind_t kw,
                                          input logic st, input logic fl);
    logic [1:0] aluop;
    logic       alusrc, regdst;
    aluop  = 2'b00;
    alusrc = 1'b0;
    regdst = 1'b0;
    case (ki)
      KR: begin aluop = 2'b10; regdst = 1'b1; end
      KL: alusrc = 1'b1;
      KS: alusrc = 1'b1;
      KQ: aluop = 2'b01;
      KI: aluop = 2'b11;
      default: ;
    endcase
    return {aluop, alusrc, regdst, (ke == KL), (ke == KS), (kw == KR || kw == KL), (kw == KL),
            ~st, ~st, fl, fl};
  endfunction

  task automatic vec(input string nm, input logic r, input logic [5:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic mz, input kind_t ki, input kind_t ke,
                     input kind_t kw, input logic st, input logic fl, input int cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    opcode   = op;
    if_id_rs = rs;
    if_id_rt = rt;
    mem_zero = mz;
    e.nm  = nm;
    e.ctl = exp_ctl(ki, ke, kw, st, fl);
`ifdef STALL_COUNT_EN
    e.cnt = 4'(cnt);
`else
    e.cnt = 4'(cnt * 0);
`endif
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      automatic exp_t        e   = q.pop_front();
      automatic logic [11:0] got = {ex_aluop, ex_alusrc, ex_regdst, mem_read, mem_write,
                                    wb_regwrite, wb_memtoreg, pc_write, if_id_write,
                                    if_flush, pc_src};
      n_vec++;
      if ({got, stall_cnt} !== {e.ctl, e.cnt}) begin
        n_err++;
        $display("FAIL %s @%0t: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 e.nm, $time, got, stall_cnt, e.ctl, e.cnt);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    opcode   = OpR;
    if_id_rs = 5'd0;
    if_id_rt = 5'd0;
    mem_zero = 1'b0;

    // Reset release and R-type flowing down the pipe
    vec("rst_hold",   1, OpR, 1, 2, 0, KB, KB, KB, 0, 0, 0);
    vec("rst_rel",    0, OpR, 1, 2, 0, KB, KB, KB, 0, 0, 0);
    vec("r_ex",       0, OpR, 1, 2, 0, KR, KB, KB, 0, 0, 0);
    vec("r_mem",      0, OpR, 1, 2, 0, KR, KR, KB, 0, 0, 0);
    vec("r_wb",       0, OpR, 1, 2, 0, KR, KR, KR, 0, 0, 0);
    // lw rt=5 followed by consumer of r5
    vec("lw_issue",   0, OpLw, 1, 5, 0, KR, KR, KR, 0, 0, 0);
    vec("lu_stall",   0, OpR, 5, 6, 0, KL, KR, KR, 1, 0, 0);
    vec("lu_bubble",  0, OpR, 5, 6, 0, KB, KL, KR, 0, 0, 1);
    vec("lu_resume",  0, OpR, 7, 8, 0, KR, KB, KL, 0, 0, 1);
    // lw into r0 never stalls
    vec("lw0_issue",  0, OpLw, 1, 0, 0, KR, KR, KB, 0, 0, 1);
    vec("lw0_nostl",  0, OpR, 0, 0, 0, KL, KR, KR, 0, 0, 1);
    vec("lw0_flow1",  0, OpR, 1, 2, 0, KR, KL, KR, 0, 0, 1);
    vec("lw0_flow2",  0, OpR, 1, 2, 0, KR, KR, KL, 0, 0, 1);
    // lw then lw with matching rt: no stall; then sw with matching rt: stall
    vec("lwlw_iss",   0, OpLw, 1, 9, 0, KR, KR, KR, 0, 0, 1);
    vec("lwlw_nostl", 0, OpLw, 1, 9, 0, KL, KR, KR, 0, 0, 1);
    vec("lwsw_stall", 0, OpSw, 2, 9, 0, KL, KL, KR, 1, 0, 1);
    vec("lwsw_bub",   0, OpSw, 2, 9, 0, KB, KL, KL, 0, 0, 2);
    vec("sw_ex",      0, OpR, 1, 2, 0, KS, KB, KL, 0, 0, 2);
    vec("sw_mem",     0, OpR, 1, 2, 0, KR, KS, KB, 0, 0, 2);
    vec("sw_wb",      0, OpR, 1, 2, 0, KR, KR, KS, 0, 0, 2);
    // Taken branch flushes ID/EX and EX/MEM
    vec("beq_issue",  0, OpBeq, 1, 2, 0, KR, KR, KR, 0, 0, 2);
    vec("beq_ex",     0, OpLw, 1, 3, 0, KQ, KR, KR, 0, 0, 2);
    vec("beq_taken",  0, OpSw, 4, 5, 1, KL, KQ, KR, 0, 1, 2);
    vec("flush_bub",  0, OpR, 1, 2, 1, KB, KB, KQ, 0, 0, 2);
    vec("flush_aft",  0, OpR, 1, 2, 0, KR, KB, KB, 0, 0, 2);
    // Taken branch together with load-use: flush wins, no stall counted
    vec("bl_beq",     0, OpBeq, 1, 2, 0, KR, KR, KB, 0, 0, 2);
    vec("bl_lw",      0, OpLw, 1, 7, 0, KQ, KR, KR, 0, 0, 2);
    vec("bl_both",    0, OpR, 7, 1, 1, KL, KQ, KR, 0, 1, 2);
    vec("bl_bub",     0, OpInv, 7, 1, 0, KB, KB, KQ, 0, 0, 2);
    vec("inv_ex",     0, OpR, 1, 2, 0, KI, KB, KB, 0, 0, 2);
    vec("inv_mem",    0, OpR, 1, 2, 0, KR, KI, KB, 0, 0, 2);
    vec("inv_wb",     0, OpR, 1, 2, 0, KR, KR, KI, 0, 0, 2);
    // Untaken branch passes through without flushing
    vec("nt_issue",   0, OpBeq, 1, 2, 0, KR, KR, KR, 0, 0, 2);
    vec("nt_ex",      0, OpR, 1, 2, 0, KQ, KR, KR, 0, 0, 2);
    vec("nt_mem",     0, OpR, 1, 2, 0, KR, KQ, KR, 0, 0, 2);
    vec("nt_wb",      0, OpR, 1, 2, 0, KR, KR, KQ, 0, 0, 2);
    // Repeated stalls until the 4-bit counter saturates
    vec("sat_pre",    0, OpLw, 5, 5, 0, KR, KR, KR, 0, 0, 2);
    vec("sat_st0",    0, OpLw, 5, 5, 0, KL, KR, KR, 1, 0, 2);
    vec("sat_bu0",    0, OpLw, 5, 5, 0, KB, KL, KR, 0, 0, 3);
    for (int i = 0; i < 14; i++) begin
      vec("sat_stall", 0, OpLw, 5, 5, 0, KL, KB, KL, 1, 0, (3 + i > 15) ? 15 : 3 + i);
      vec("sat_bub",   0, OpLw, 5, 5, 0, KB, KL, KB, 0, 0, (4 + i > 15) ? 15 : 4 + i);
    end
    // Reset in the middle of a stall
    vec("rst_stall",  1, OpLw, 5, 5, 0, KB, KB, KB, 0, 0, 0);
    vec("post_rst",   0, OpR, 5, 5, 0, KB, KB, KB, 0, 0, 0);
    vec("post_dec",   0, OpR, 1, 2, 0, KR, KB, KB, 0, 0, 0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
